// File: rtl/sc_level_pkg.sv
// Shared types, mode constants and load clamp for the Space Invaders level sequencer.
package sc_level_pkg;

  localparam int SC_LEVEL_MODE_SAT  = 0;
  localparam int SC_LEVEL_MODE_WRAP = 1;

  typedef enum logic {
    ARMED   = 1'b0,
    LOCKOUT = 1'b1
  } level_state_t;

  // Works on 32-bit values so any module width can use it before truncating.
  function automatic logic [31:0] clamp_level(input logic [31:0] value,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    logic [31:0] result;
    result = value;
    if (value < lo) begin
      result = lo;
    end else if (value > hi) begin
      result = hi;
    end
    return result;
  endfunction

endpackage

// File: rtl/sc_level_sequencer_edge_sync.sv
// Two-flop synchroniser with a falling-edge pulse; idles high so a push-button at rest reads 1.
module sc_edge_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic fall
);

  logic       meta;
  logic       stable;
  logic       prev;
  logic [1:0] valid;

  // prev only trusts stable once it holds a genuinely sampled value, so a line
  // already low when reset releases cannot fake a falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b1;
      stable <= 1'b1;
      prev   <= 1'b0;
      valid  <= 2'b00;
    end else begin
      meta   <= raw;
      stable <= meta;
      valid  <= {valid[0], 1'b1};
      prev   <= stable & valid[1];
    end
  end

  assign fall = prev & ~stable;

endmodule

// File: rtl/sc_level_sequencer.sv
// Game-level counter fed by a synchronised falling-edge request.
// Optional event lockout built when SC_LEVEL_LOCKOUT_EN is defined.
module sc_level_sequencer
  import sc_level_pkg::*;
#(
  parameter int COUNTER_DATAWIDTH_BUS  = 4,
  parameter int COUNTER_MIN_LEVEL      = 0,
  parameter int COUNTER_MAX_LEVEL      = 9,
  parameter int COUNTER_WRAP_MODE      = 0,
  parameter int COUNTER_LOCKOUT_CYCLES = 1024
) (
  input  logic                             SC_COUNTER_CLOCK_50,
  input  logic                             SC_COUNTER_RESET_InLow,
  input  logic                             SC_COUNTER_count_InLow,
  input  logic                             SC_COUNTER_clear_InLow,
  input  logic                             SC_COUNTER_load_InLow,
  input  logic [COUNTER_DATAWIDTH_BUS-1:0] SC_COUNTER_data_InBus,
  output logic [COUNTER_DATAWIDTH_BUS-1:0] SC_COUNTER_regcount_OutBus,
  output logic                             SC_COUNTER_levelup_Out,
  output logic                             SC_COUNTER_wrap_Out,
  output logic                             SC_COUNTER_last_Out
);

  localparam int W  = COUNTER_DATAWIDTH_BUS;
  localparam int WE = COUNTER_DATAWIDTH_BUS + 1;

  localparam logic [W-1:0]  MIN_LVL    = W'(COUNTER_MIN_LEVEL);
  localparam logic [W-1:0]  MAX_LVL    = W'(COUNTER_MAX_LEVEL);
  localparam logic [WE-1:0] MAX_EXT    = WE'(COUNTER_MAX_LEVEL);
  localparam logic          MIN_IS_MAX = (COUNTER_MIN_LEVEL == COUNTER_MAX_LEVEL);
  localparam logic          WRAP_EN    = (COUNTER_WRAP_MODE == SC_LEVEL_MODE_WRAP);

  if (COUNTER_MIN_LEVEL < 0 || COUNTER_MIN_LEVEL >= COUNTER_MAX_LEVEL ||
      COUNTER_MAX_LEVEL >= (1 << COUNTER_DATAWIDTH_BUS) ||
      (COUNTER_WRAP_MODE != SC_LEVEL_MODE_SAT && COUNTER_WRAP_MODE != SC_LEVEL_MODE_WRAP) ||
      COUNTER_LOCKOUT_CYCLES < 1) begin : g_bad_params
    $error("sc_level_sequencer: inconsistent level parameters");
  end

`ifdef SC_LEVEL_LOCKOUT_EN
  localparam int LW = (COUNTER_LOCKOUT_CYCLES > 1) ? $clog2(COUNTER_LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(COUNTER_LOCKOUT_CYCLES - 1);
  logic [LW-1:0] lock_cnt;
`endif

  level_state_t  state;
  logic          req_event;
  logic [WE-1:0] level_inc;
  logic          at_max;
  logic          accept;
  logic [W-1:0]  step_level;
  logic [W-1:0]  load_val;

  sc_edge_sync u_count_sync (
    .clock   (SC_COUNTER_CLOCK_50),
    .reset_n (SC_COUNTER_RESET_InLow),
    .raw     (SC_COUNTER_count_InLow),
    .fall    (req_event)
  );

  // The extra top bit keeps the increment from rolling over silently, so the
  // MAX comparison is exact even when MAX is the largest encodable value.
  always_comb begin
    level_inc  = {1'b0, SC_COUNTER_regcount_OutBus} + WE'(1);
    at_max     = (level_inc > MAX_EXT);
    accept     = req_event && (state == ARMED) && (!at_max || WRAP_EN);
    step_level = at_max ? MIN_LVL : level_inc[W-1:0];
    load_val   = W'(clamp_level(32'(SC_COUNTER_data_InBus),
                                32'(COUNTER_MIN_LEVEL), 32'(COUNTER_MAX_LEVEL)));
  end

  // Clear beats load beats a request; a request that loses is simply dropped.
  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      SC_COUNTER_regcount_OutBus <= MIN_LVL;
      SC_COUNTER_levelup_Out     <= 1'b0;
      SC_COUNTER_wrap_Out        <= 1'b0;
      SC_COUNTER_last_Out        <= MIN_IS_MAX;
      state                      <= ARMED;
`ifdef SC_LEVEL_LOCKOUT_EN
      lock_cnt                   <= '0;
`endif
    end else begin
      SC_COUNTER_levelup_Out <= 1'b0;
      SC_COUNTER_wrap_Out    <= 1'b0;
      if (!SC_COUNTER_clear_InLow) begin
        SC_COUNTER_regcount_OutBus <= MIN_LVL;
        SC_COUNTER_last_Out        <= MIN_IS_MAX;
        state                      <= ARMED;
`ifdef SC_LEVEL_LOCKOUT_EN
        lock_cnt                   <= '0;
`endif
      end else if (!SC_COUNTER_load_InLow) begin
        SC_COUNTER_regcount_OutBus <= load_val;
        SC_COUNTER_last_Out        <= (load_val == MAX_LVL);
        state                      <= ARMED;
`ifdef SC_LEVEL_LOCKOUT_EN
        lock_cnt                   <= '0;
`endif
      end else if (accept) begin
        SC_COUNTER_regcount_OutBus <= step_level;
        SC_COUNTER_last_Out        <= (step_level == MAX_LVL);
        SC_COUNTER_levelup_Out     <= 1'b1;
        SC_COUNTER_wrap_Out        <= at_max;
`ifdef SC_LEVEL_LOCKOUT_EN
        state                      <= LOCKOUT;
        lock_cnt                   <= LOCK_LOAD;
`endif
      end
`ifdef SC_LEVEL_LOCKOUT_EN
      else if (state == LOCKOUT) begin
        if (lock_cnt == '0) begin
          state <= ARMED;
        end else begin
          lock_cnt <= lock_cnt - LW'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Directed bench for sc_level_sequencer: three instances (saturate, wrap, MIN = 2) share one stimulus.
module tb_sc_level_sequencer;

  logic       clk;
  logic       rst_n;
  logic       count_n;
  logic       clear_n;
  logic       load_n;
  logic [3:0] data;

  logic [3:0] sat_level, wrp_level, min2_level;
  logic       sat_up, wrp_up, min2_up;
  logic       sat_wrap, wrp_wrap, min2_wrap;
  logic       sat_last, wrp_last, min2_last;

  int checks_done = 0;
  int fail_count  = 0;

  sc_level_sequencer #(
    .COUNTER_DATAWIDTH_BUS(4), .COUNTER_MIN_LEVEL(0), .COUNTER_MAX_LEVEL(9),
    .COUNTER_WRAP_MODE(0), .COUNTER_LOCKOUT_CYCLES(8)
  ) dut_sat (
    .SC_COUNTER_CLOCK_50(clk), .SC_COUNTER_RESET_InLow(rst_n),
    .SC_COUNTER_count_InLow(count_n), .SC_COUNTER_clear_InLow(clear_n),
    .SC_COUNTER_load_InLow(load_n), .SC_COUNTER_data_InBus(data),
    .SC_COUNTER_regcount_OutBus(sat_level), .SC_COUNTER_levelup_Out(sat_up),
    .SC_COUNTER_wrap_Out(sat_wrap), .SC_COUNTER_last_Out(sat_last)
  );

  sc_level_sequencer #(
    .COUNTER_DATAWIDTH_BUS(4), .COUNTER_MIN_LEVEL(0), .COUNTER_MAX_LEVEL(9),
    .COUNTER_WRAP_MODE(1), .COUNTER_LOCKOUT_CYCLES(8)
  ) dut_wrap (
    .SC_COUNTER_CLOCK_50(clk), .SC_COUNTER_RESET_InLow(rst_n),
    .SC_COUNTER_count_InLow(count_n), .SC_COUNTER_clear_InLow(clear_n),
    .SC_COUNTER_load_InLow(load_n), .SC_COUNTER_data_InBus(data),
    .SC_COUNTER_regcount_OutBus(wrp_level), .SC_COUNTER_levelup_Out(wrp_up),
    .SC_COUNTER_wrap_Out(wrp_wrap), .SC_COUNTER_last_Out(wrp_last)
  );

  sc_level_sequencer #(
    .COUNTER_DATAWIDTH_BUS(4), .COUNTER_MIN_LEVEL(2), .COUNTER_MAX_LEVEL(9),
    .COUNTER_WRAP_MODE(0), .COUNTER_LOCKOUT_CYCLES(8)
  ) dut_min2 (
    .SC_COUNTER_CLOCK_50(clk), .SC_COUNTER_RESET_InLow(rst_n),
    .SC_COUNTER_count_InLow(count_n), .SC_COUNTER_clear_InLow(clear_n),
    .SC_COUNTER_load_InLow(load_n), .SC_COUNTER_data_InBus(data),
    .SC_COUNTER_regcount_OutBus(min2_level), .SC_COUNTER_levelup_Out(min2_up),
    .SC_COUNTER_wrap_Out(min2_wrap), .SC_COUNTER_last_Out(min2_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a falling edge and outputs are read at later falling edges.
  task automatic applyStimulus(input logic cnt, input logic clr, input logic ld,
                               input logic [3:0] value, input int cycles);
    count_n = cnt;
    clear_n = clr;
    load_n  = ld;
    data    = value;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_done++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    count_n = 1'b1;
    clear_n = 1'b1;
    load_n  = 1'b1;
    data    = 4'd0;
    repeat (3) @(negedge clk);

    checkOutput("reset_level", 32'(sat_level), 0);
    checkOutput("reset_levelup", 32'(sat_up), 0);
    checkOutput("reset_wrap", 32'(sat_wrap), 0);
    checkOutput("reset_last", 32'(sat_last), 0);
    checkOutput("reset_min2_level", 32'(min2_level), 2);
    checkOutput("reset_min2_wrap", 32'(min2_wrap), 0);

    rst_n = 1'b1;
    applyStimulus(1, 1, 1, 0, 5);

    $display("[TB] three spaced requests");
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 1, 1, 0, 1);
      checkOutput("lat_edge1_level", 32'(sat_level), 32'(k - 1));
      applyStimulus(0, 1, 1, 0, 1);
      checkOutput("lat_edge2_level", 32'(sat_level), 32'(k - 1));
      checkOutput("lat_edge2_levelup", 32'(sat_up), 0);
      applyStimulus(0, 1, 1, 0, 1);
      checkOutput("lat_edge3_level", 32'(sat_level), 32'(k));
      checkOutput("lat_edge3_levelup", 32'(sat_up), 1);
      checkOutput("lat_wrapdut_level", 32'(wrp_level), 32'(k));
      checkOutput("lat_min2_level", 32'(min2_level), 32'(k + 2));
      applyStimulus(1, 1, 1, 0, 1);
      checkOutput("lat_levelup_drop", 32'(sat_up), 0);
      applyStimulus(1, 1, 1, 0, 6);
    end

    $display("[TB] load 9 then requests at MAX");
    applyStimulus(1, 1, 0, 4'd9, 1);
    checkOutput("load9_level", 32'(sat_level), 9);
    checkOutput("load9_last", 32'(sat_last), 1);
    checkOutput("load9_levelup", 32'(sat_up), 0);
    checkOutput("load9_wrapdut_level", 32'(wrp_level), 9);
    applyStimulus(1, 1, 1, 0, 5);

    applyStimulus(0, 1, 1, 0, 3);
    checkOutput("sat_ev1_level", 32'(sat_level), 9);
    checkOutput("sat_ev1_levelup", 32'(sat_up), 0);
    checkOutput("sat_ev1_wrap", 32'(sat_wrap), 0);
    checkOutput("sat_ev1_last", 32'(sat_last), 1);
    checkOutput("wrap_ev_level", 32'(wrp_level), 0);
    checkOutput("wrap_ev_levelup", 32'(wrp_up), 1);
    checkOutput("wrap_ev_wrap", 32'(wrp_wrap), 1);
    checkOutput("wrap_ev_last", 32'(wrp_last), 0);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("wrap_ev_levelup_drop", 32'(wrp_up), 0);
    checkOutput("wrap_ev_wrap_drop", 32'(wrp_wrap), 0);
    applyStimulus(1, 1, 1, 0, 6);

    applyStimulus(0, 1, 1, 0, 3);
    checkOutput("sat_ev2_level", 32'(sat_level), 9);
    checkOutput("sat_ev2_levelup", 32'(sat_up), 0);
    checkOutput("sat_ev2_wrap", 32'(sat_wrap), 0);
    checkOutput("wrap_after_level", 32'(wrp_level), 1);
    checkOutput("wrap_after_levelup", 32'(wrp_up), 1);
    checkOutput("wrap_after_wrap", 32'(wrp_wrap), 0);
    applyStimulus(1, 1, 1, 0, 6);

    $display("[TB] load clamping and clear priority");
    applyStimulus(1, 1, 0, 4'd15, 1);
    checkOutput("clamp_hi_min2", 32'(min2_level), 9);
    checkOutput("clamp_hi_min2_last", 32'(min2_last), 1);
    checkOutput("clamp_hi_sat", 32'(sat_level), 9);
    applyStimulus(1, 1, 0, 4'd0, 1);
    checkOutput("clamp_lo_min2", 32'(min2_level), 2);
    checkOutput("clamp_lo_min2_last", 32'(min2_last), 0);
    checkOutput("clamp_lo_sat", 32'(sat_level), 0);
    applyStimulus(1, 1, 0, 4'd5, 1);
    checkOutput("load5_sat", 32'(sat_level), 5);
    applyStimulus(1, 1, 1, 0, 2);

    applyStimulus(0, 1, 1, 0, 2);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("clear_ev_level", 32'(sat_level), 0);
    checkOutput("clear_ev_min2_level", 32'(min2_level), 2);
    checkOutput("clear_ev_levelup", 32'(sat_up), 0);
    checkOutput("clear_ev_wrapdut_up", 32'(wrp_up), 0);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("clear_ev_after_level", 32'(sat_level), 0);
    checkOutput("clear_ev_after_levelup", 32'(sat_up), 0);
    applyStimulus(1, 1, 1, 0, 6);

    $display("[TB] held request and reset with request low");
    applyStimulus(1, 1, 0, 4'd4, 1);
    applyStimulus(1, 1, 1, 0, 3);
    applyStimulus(0, 1, 1, 0, 100);
    checkOutput("hold_low_level", 32'(sat_level), 5);
    checkOutput("hold_low_min2_level", 32'(min2_level), 5);
    checkOutput("hold_low_levelup", 32'(sat_up), 0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_level", 32'(sat_level), 0);
    checkOutput("async_reset_min2_level", 32'(min2_level), 2);
    applyStimulus(0, 1, 1, 0, 2);
    rst_n = 1'b1;
    applyStimulus(0, 1, 1, 0, 10);
    checkOutput("post_reset_level", 32'(sat_level), 0);
    checkOutput("post_reset_levelup", 32'(sat_up), 0);
    applyStimulus(1, 1, 1, 0, 5);
    applyStimulus(0, 1, 1, 0, 3);
    checkOutput("rearm_level", 32'(sat_level), 1);
    checkOutput("rearm_levelup", 32'(sat_up), 1);
    applyStimulus(1, 1, 1, 0, 12);

    $display("[TB] requests at 0, 4 and 12 cycles");
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("pre_burst_level", 32'(sat_level), 0);
    applyStimulus(1, 1, 1, 0, 3);
    applyStimulus(0, 1, 1, 0, 3);
    checkOutput("burst_ev0_level", 32'(sat_level), 1);
    checkOutput("burst_ev0_levelup", 32'(sat_up), 1);
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(0, 1, 1, 0, 3);
`ifdef SC_LEVEL_LOCKOUT_EN
    checkOutput("burst_ev4_level", 32'(sat_level), 1);
    checkOutput("burst_ev4_levelup", 32'(sat_up), 0);
`else
    checkOutput("burst_ev4_level", 32'(sat_level), 2);
    checkOutput("burst_ev4_levelup", 32'(sat_up), 1);
`endif
    applyStimulus(1, 1, 1, 0, 5);
    applyStimulus(0, 1, 1, 0, 3);
`ifdef SC_LEVEL_LOCKOUT_EN
    checkOutput("burst_ev12_level", 32'(sat_level), 2);
`else
    checkOutput("burst_ev12_level", 32'(sat_level), 3);
`endif
    checkOutput("burst_ev12_levelup", 32'(sat_up), 1);
    applyStimulus(1, 1, 1, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
    $finish;
  end

endmodule
